// File: rtl/memory_game_ctrl_pkg.sv
// Shared definitions for the memory game controller.
// Contents: the code width, the default parameter values, the FSM state
// encoding and small helper functions.
package memory_game_ctrl_pkg;

    localparam int CODE_W = 4;

    localparam int DEF_MAX_LEN        = 8;
    localparam int DEF_SHOW_CYCLES    = 4;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GEN      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_GAP = 3'd3,
        ST_INPUT    = 3'd4,
        ST_WIN      = 3'd5,
        ST_FAIL     = 3'd6
    } state_e;

    // An all-zero code is the LFSR lock-up value, so it is stored as 1.
    function automatic logic [CODE_W-1:0] fix_code(input logic [CODE_W-1:0] raw);
        return (raw == '0) ? CODE_W'(1) : raw;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/memory_game_ctrl_if.sv
// Player/display bus of the memory game controller.
// Inputs to the controller: start, rnd_in, key_valid, key_code.
// Outputs from the controller: disp_valid, disp_code, expecting_input,
// level, busy, win, fail.
interface memory_game_ctrl_if;
    import memory_game_ctrl_pkg::*;

    logic              start;
    logic [CODE_W-1:0] rnd_in;
    logic              key_valid;
    logic [CODE_W-1:0] key_code;
    logic              disp_valid;
    logic [CODE_W-1:0] disp_code;
    logic              expecting_input;
    logic [3:0]        level;
    logic              busy;
    logic              win;
    logic              fail;

    modport master (
        output start, rnd_in, key_valid, key_code,
        input  disp_valid, disp_code, expecting_input, level, busy, win, fail
    );

    modport slave (
        input  start, rnd_in, key_valid, key_code,
        output disp_valid, disp_code, expecting_input, level, busy, win, fail
    );

endinterface

// File: rtl/memory_game_ctrl_seq_store.sv
// Sequence register file: DEPTH entries of CODE_W bits, one synchronous
// write port, one asynchronous read port, synchronous clear-all.
// Ports: CLK, RST_N (async active-low), clr_i, we_i, waddr_i, wdata_i,
// raddr_i, rdata_o.
module seq_store
    import memory_game_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_LEN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              clr_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [CODE_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [CODE_W-1:0] rdata_o
);

    logic [CODE_W-1:0] mem_q [DEPTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/memory_game_ctrl.sv
// Memory game controller: grows a random sequence one element per level,
// shows it, then checks the player's keys against it.
// Ports: CLK, RST_N (async active-low), bus (memory_game_ctrl_if.slave).
//
// state       | meaning
// ------------+-----------------------------------------------------
// IDLE        | no game since reset
// GEN         | append rnd_in to the sequence (one cycle)
// SHOW_ON     | present seq[idx] for SHOW_CYCLES cycles
// SHOW_GAP    | blank display for GAP_CYCLES cycles
// INPUT       | wait for the player's key for seq[idx], with timeout
// WIN         | full sequence repeated at MAX_LEN, waits for start
// FAIL        | wrong key or timeout, waits for start
module memory_game_ctrl
    import memory_game_ctrl_pkg::*;
#(
    parameter int MAX_LEN        = DEF_MAX_LEN,
    parameter int SHOW_CYCLES    = DEF_SHOW_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic          CLK,
    input  logic          RST_N,
    memory_game_ctrl_if.slave bus
);

    localparam int LVL_W = $clog2(MAX_LEN + 1);
    localparam int AW    = $clog2(MAX_LEN);
    localparam int CNT_W = $clog2(max3(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES) + 1);

    // Down-counter loads: each phase ends on the cycle the counter reads 0.
    localparam logic [CNT_W-1:0] SHOW_LD = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEN);

    state_e            state_q, state_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              seq_clr, seq_we;
    logic [CODE_W-1:0] seq_rd;
    logic              idle_like, last_elem;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_WIN) || (state_q == ST_FAIL);
    assign last_elem = (idx_q == level_q - LVL_ONE);

    seq_store #(.DEPTH(MAX_LEN), .AW(AW)) u_seq_store (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .clr_i   (seq_clr),
        .we_i    (seq_we),
        .waddr_i (AW'(level_q - LVL_ONE)),
        .wdata_i (fix_code(bus.rnd_in)),
        .raddr_i (AW'(idx_q)),
        .rdata_o (seq_rd)
    );

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        seq_clr = 1'b0;
        seq_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_WIN, ST_FAIL: begin
                if (bus.start) begin
                    state_d = ST_GEN;
                    level_d = LVL_ONE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    seq_clr = 1'b1;
                end
            end
            ST_GEN: begin
                seq_we  = 1'b1;
                idx_d   = '0;
                cnt_d   = SHOW_LD;
                state_d = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (cnt_q == '0) begin
                    cnt_d   = GAP_LD;
                    state_d = ST_SHOW_GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SHOW_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!last_elem) begin
                    idx_d   = idx_q + LVL_ONE;
                    cnt_d   = SHOW_LD;
                    state_d = ST_SHOW_ON;
                end else begin
                    idx_d   = '0;
                    cnt_d   = TO_LD;
                    state_d = ST_INPUT;
                end
            end
            ST_INPUT: begin
                // A key on the expiry cycle wins over the timeout.
                if (bus.key_valid) begin
                    if (bus.key_code != seq_rd) begin
                        state_d = ST_FAIL;
                    end else if (!last_elem) begin
                        idx_d = idx_q + LVL_ONE;
                        cnt_d = TO_LD;
                    end else if (level_q == LVL_MAX) begin
                        state_d = ST_WIN;
                    end else begin
                        level_d = level_q + LVL_ONE;
                        idx_d   = '0;
                        state_d = ST_GEN;
                    end
                end else if (cnt_q == '0) begin
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            level_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.disp_valid      = (state_q == ST_SHOW_ON);
    assign bus.disp_code       = (state_q == ST_SHOW_ON) ? seq_rd : '0;
    assign bus.expecting_input = (state_q == ST_INPUT);
    assign bus.level           = 4'(level_q);
    assign bus.busy            = !idle_like;
    assign bus.win             = (state_q == ST_WIN);
    assign bus.fail            = (state_q == ST_FAIL);

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl: instance A uses default parameters,
// instance B uses MAX_LEN=2 for the winning game.
module tb_memory_game_ctrl;
    import memory_game_ctrl_pkg::*;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    memory_game_ctrl_if ia();
    memory_game_ctrl_if ib();

    memory_game_ctrl u_dut_a (.CLK(CLK), .RST_N(RST_N), .bus(ia));
    memory_game_ctrl #(.MAX_LEN(2)) u_dut_b (.CLK(CLK), .RST_N(RST_N), .bus(ib));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic expect_st(input bit sel, input string tag, input logic dv,
                             input logic [3:0] dc, input logic ei, input logic [3:0] lv,
                             input logic bz, input logic w, input logic f);
        check({tag, ".disp_valid"}, sel ? ib.disp_valid      : ia.disp_valid,      dv);
        check({tag, ".disp_code"},  sel ? ib.disp_code       : ia.disp_code,       dc);
        check({tag, ".expecting"},  sel ? ib.expecting_input : ia.expecting_input, ei);
        check({tag, ".level"},      sel ? ib.level           : ia.level,           lv);
        check({tag, ".busy"},       sel ? ib.busy            : ia.busy,            bz);
        check({tag, ".win"},        sel ? ib.win             : ia.win,             w);
        check({tag, ".fail"},       sel ? ib.fail            : ia.fail,            f);
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) ib.start = 1'b1; else ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        ib.start = 1'b0;
    endtask

    task automatic pulse_key(input bit sel, input logic [3:0] code);
        if (sel) begin ib.key_code = code; ib.key_valid = 1'b1; end
        else     begin ia.key_code = code; ia.key_valid = 1'b1; end
        tick();
        ia.key_valid = 1'b0;
        ib.key_valid = 1'b0;
    endtask

    initial begin
        ia.start = 1'b0; ia.rnd_in = '0; ia.key_valid = 1'b0; ia.key_code = '0;
        ib.start = 1'b0; ib.rnd_in = '0; ib.key_valid = 1'b0; ib.key_code = '0;

        ticks(2);
        expect_st(0, "rst_a", 0, 0, 0, 0, 0, 0, 0);
        expect_st(1, "rst_b", 0, 0, 0, 0, 0, 0, 0);

        // Start on the very edge reset is released for.
        RST_N = 1'b1; ia.rnd_in = 4'h5; ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        expect_st(0, "s1_gen", 0, 0, 0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); expect_st(0, "s1_show", 1, 5, 0, 1, 1, 0, 0);
        end
        for (int i = 0; i < 2; i++) begin
            tick(); expect_st(0, "s1_gap", 0, 0, 0, 1, 1, 0, 0);
        end
        tick(); expect_st(0, "s1_input", 0, 0, 1, 1, 1, 0, 0);

        // Timeout: 64 idle INPUT cycles, then FAIL.
        ticks(63); expect_st(0, "to_c64", 0, 0, 1, 1, 1, 0, 0);
        tick();    expect_st(0, "to_fail", 0, 0, 0, 1, 0, 0, 1);
        pulse_key(0, 4'h5);
        expect_st(0, "fail_key_ign", 0, 0, 0, 1, 0, 0, 1);

        // Correct key on the expiry cycle advances instead of failing.
        ia.rnd_in = 4'h7;
        pulse_start(0);
        expect_st(0, "s4_gen", 0, 0, 0, 1, 1, 0, 0);
        ticks(7);  expect_st(0, "s4_input", 0, 0, 1, 1, 1, 0, 0);
        ticks(63); expect_st(0, "s4_c64", 0, 0, 1, 1, 1, 0, 0);
        ia.rnd_in = 4'h0;
        pulse_key(0, 4'h7);
        expect_st(0, "s4_key_wins", 0, 0, 0, 2, 1, 0, 0);

        // rnd_in=0 is stored as 1; start/key during SHOW are ignored.
        tick();    expect_st(0, "s5_el0", 1, 7, 0, 2, 1, 0, 0);
        ticks(6);  expect_st(0, "s5_rnd0", 1, 1, 0, 2, 1, 0, 0);
        ia.start = 1'b1; ia.key_valid = 1'b1; ia.key_code = 4'h1;
        tick();
        ia.start = 1'b0; ia.key_valid = 1'b0;
        expect_st(0, "s5_ignore", 1, 1, 0, 2, 1, 0, 0);
        ticks(3);  expect_st(0, "s5_gap", 0, 0, 0, 2, 1, 0, 0);
        ticks(2);  expect_st(0, "s5_input", 0, 0, 1, 2, 1, 0, 0);
        pulse_key(0, 4'h7);
        expect_st(0, "s5_key0", 0, 0, 1, 2, 1, 0, 0);
        ia.rnd_in = 4'h2;
        pulse_key(0, 4'h1);
        expect_st(0, "s5_lvl3", 0, 0, 0, 3, 1, 0, 0);
        tick();    expect_st(0, "s6_pre", 1, 7, 0, 3, 1, 0, 0);

        // Asynchronous reset in the middle of SHOW_ON.
        #2 RST_N = 1'b0;
        #1 expect_st(0, "s6_async", 0, 0, 0, 0, 0, 0, 0);
        tick();
        RST_N = 1'b1; ia.rnd_in = 4'h7; ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        expect_st(0, "s6_gen", 0, 0, 0, 1, 1, 0, 0);
        tick();    expect_st(0, "s6_replay", 1, 7, 0, 1, 1, 0, 0);
        ticks(6);  expect_st(0, "s3_input", 0, 0, 1, 1, 1, 0, 0);

        // Wrong key at level 1.
        pulse_key(0, 4'h6);
        expect_st(0, "s3_fail", 0, 0, 0, 1, 0, 0, 1);

        // Winning game on the MAX_LEN=2 instance.
        ib.rnd_in = 4'h3;
        pulse_start(1);
        expect_st(1, "s2_gen1", 0, 0, 0, 1, 1, 0, 0);
        ticks(7);  expect_st(1, "s2_input1", 0, 0, 1, 1, 1, 0, 0);
        pulse_key(1, 4'h3);
        expect_st(1, "s2_gen2", 0, 0, 0, 2, 1, 0, 0);
        ib.rnd_in = 4'h9;
        ticks(7);  expect_st(1, "s2_el1", 1, 9, 0, 2, 1, 0, 0);
        ticks(6);  expect_st(1, "s2_input2", 0, 0, 1, 2, 1, 0, 0);
        pulse_key(1, 4'h3);
        expect_st(1, "s2_key0", 0, 0, 1, 2, 1, 0, 0);
        pulse_key(1, 4'h9);
        expect_st(1, "s2_win", 0, 0, 0, 2, 0, 1, 0);
        tick();    expect_st(1, "s2_sticky", 0, 0, 0, 2, 0, 1, 0);
        ib.rnd_in = 4'h3;
        pulse_start(1);
        expect_st(1, "s2_restart", 0, 0, 0, 1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
